// File: rtl/ap_mem_responder.sv
// ap_mem_responder: two-array memory model answering HLS ap_memory ports.
// Sweeps both arrays to zero after reset, then serves kernel reads/writes
// with a fixed read latency and accepts host preloads when no kernel
// write targets the same array.
module ap_mem_responder #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic [31:0]   a_address0,
  input  logic          a_ce0,
  input  logic          a_we0,
  input  logic [DW-1:0] a_ad0,
  output logic [DW-1:0] a_q0,
  input  logic [31:0]   b_address0,
  input  logic          b_ce0,
  input  logic          b_we0,
  input  logic [DW-1:0] b_ad0,
  output logic [DW-1:0] b_q0,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_sel,
  input  logic [31:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          mem_ready,
  output logic          a_err,
  output logic          b_err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic            clr_en;

  logic [DW-1:0]   mem_a [DEPTH];
  logic [DW-1:0]   mem_b [DEPTH];

  logic            a_kwr, b_kwr, a_rd, b_rd;
  logic            a_in_rng, b_in_rng, ld_in_rng, ld_acc;
  logic [IW-1:0]   a_kidx, b_kidx, ld_idx;
  logic            a_wen, b_wen;
  logic [IW-1:0]   a_widx, b_widx;
  logic [DW-1:0]   a_wdat, b_wdat;
  logic [DW-1:0]   a_rdat, b_rdat;

  logic [RD_LAT-1:0] a_pv, b_pv;
  logic [DW-1:0]     a_pd [RD_LAT];
  logic [DW-1:0]     b_pd [RD_LAT];
  logic [DW-1:0]     a_qh, b_qh;

  assign a_kwr     = a_ce0 & a_we0;
  assign b_kwr     = b_ce0 & b_we0;
  assign a_rd      = a_ce0 & ~a_we0;
  assign b_rd      = b_ce0 & ~b_we0;
  assign a_in_rng  = a_address0 < 32'(DEPTH);
  assign b_in_rng  = b_address0 < 32'(DEPTH);
  assign ld_in_rng = ld_addr < 32'(DEPTH);
  assign a_kidx    = a_address0[IW-1:0];
  assign b_kidx    = b_address0[IW-1:0];
  assign ld_idx    = ld_addr[IW-1:0];
  assign ld_acc    = ld_valid & ld_ready;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  // Next state: leave CLEAR after the last word has been zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (idx == IW'(DEPTH - 1)) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // State-derived outputs; a kernel write to the preload target blocks the host
  always_comb begin
    clr_en    = 1'b0;
    mem_ready = 1'b0;
    ld_ready  = 1'b0;
    case (state)
      ST_CLEAR: clr_en = 1'b1;
      ST_READY: begin
        mem_ready = 1'b1;
        ld_ready  = ld_sel ? ~b_kwr : ~a_kwr;
      end
      default: clr_en = 1'b1;
    endcase
  end

  // Clear sweep index
  always_ff @(posedge ap_clk) begin
    if (ap_rst)      idx <= '0;
    else if (clr_en) idx <= idx + 1'b1;
  end

  // Write port selection: sweep, then kernel write, then host preload
  always_comb begin
    a_wen  = 1'b0;
    a_widx = a_kidx;
    a_wdat = a_ad0;
    b_wen  = 1'b0;
    b_widx = b_kidx;
    b_wdat = b_ad0;
    if (clr_en) begin
      a_wen  = 1'b1;
      a_widx = idx;
      a_wdat = '0;
      b_wen  = 1'b1;
      b_widx = idx;
      b_wdat = '0;
    end else if (mem_ready) begin
      if (a_kwr) begin
        a_wen = a_in_rng;
      end else if (ld_acc && !ld_sel) begin
        a_wen  = ld_in_rng;
        a_widx = ld_idx;
        a_wdat = ld_data;
      end
      if (b_kwr) begin
        b_wen = b_in_rng;
      end else if (ld_acc && ld_sel) begin
        b_wen  = ld_in_rng;
        b_widx = ld_idx;
        b_wdat = ld_data;
      end
    end
  end

  // Array storage
  always_ff @(posedge ap_clk) begin
    if (a_wen) mem_a[a_widx] <= a_wdat;
    if (b_wen) mem_b[b_widx] <= b_wdat;
  end

  // Read data at issue: zero during the sweep or for out-of-range addresses
  always_comb begin
    a_rdat = '0;
    b_rdat = '0;
    if (mem_ready && a_in_rng) a_rdat = mem_a[a_kidx];
    if (mem_ready && b_in_rng) b_rdat = mem_b[b_kidx];
  end

  // Read pipelines; the last stage bypasses the hold register so a result
  // is visible exactly RD_LAT cycles after issue and then held
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      a_pv <= '0;
      b_pv <= '0;
      a_qh <= '0;
      b_qh <= '0;
    end else begin
      a_pv[0] <= a_rd;
      a_pd[0] <= a_rdat;
      b_pv[0] <= b_rd;
      b_pd[0] <= b_rdat;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        a_pv[i] <= a_pv[i-1];
        a_pd[i] <= a_pd[i-1];
        b_pv[i] <= b_pv[i-1];
        b_pd[i] <= b_pd[i-1];
      end
      if (a_pv[RD_LAT-1]) a_qh <= a_pd[RD_LAT-1];
      if (b_pv[RD_LAT-1]) b_qh <= b_pd[RD_LAT-1];
    end
  end

  assign a_q0 = a_pv[RD_LAT-1] ? a_pd[RD_LAT-1] : a_qh;
  assign b_q0 = b_pv[RD_LAT-1] ? b_pd[RD_LAT-1] : b_qh;

  // Sticky out-of-range flags, only armed once the sweep is done
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      a_err <= 1'b0;
      b_err <= 1'b0;
    end else if (mem_ready) begin
      if (a_ce0 && !a_in_rng)                 a_err <= 1'b1;
      if (b_ce0 && !b_in_rng)                 b_err <= 1'b1;
      if (ld_acc && !ld_sel && !ld_in_rng)    a_err <= 1'b1;
      if (ld_acc && ld_sel && !ld_in_rng)     b_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_mem_responder.sv
// Directed testbench for ap_mem_responder (DEPTH=64, DW=32, RD_LAT=2).
module tb_ap_mem_responder;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] a_address0, b_address0, ld_addr;
  logic        a_ce0, a_we0, b_ce0, b_we0;
  logic [31:0] a_ad0, b_ad0, a_q0, b_q0, ld_data;
  logic        ld_valid, ld_ready, ld_sel, mem_ready, a_err, b_err;

  int checks = 0;
  int errors = 0;

  ap_mem_responder #(.DEPTH(64), .DW(32), .RD_LAT(2)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .a_address0(a_address0), .a_ce0(a_ce0), .a_we0(a_we0), .a_ad0(a_ad0), .a_q0(a_q0),
    .b_address0(b_address0), .b_ce0(b_ce0), .b_we0(b_we0), .b_ad0(b_ad0), .b_q0(b_q0),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .mem_ready(mem_ready), .a_err(a_err), .b_err(b_err)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle;
    a_ce0 = 0; a_we0 = 0; b_ce0 = 0; b_we0 = 0; ld_valid = 0;
  endtask

  task automatic rd_a(input logic [31:0] addr, output logic [31:0] q);
    a_ce0 = 1; a_we0 = 0; a_address0 = addr;
    tick; a_ce0 = 0;
    tick; q = a_q0;
  endtask

  task automatic rd_b(input logic [31:0] addr, output logic [31:0] q);
    b_ce0 = 1; b_we0 = 0; b_address0 = addr;
    tick; b_ce0 = 0;
    tick; q = b_q0;
  endtask

  task automatic preload(input logic sel, input logic [31:0] addr, input logic [31:0] data);
    ld_valid = 1; ld_sel = sel; ld_addr = addr; ld_data = data;
    #1 check("pl_ready", {31'd0, ld_ready}, 32'd1);
    tick; ld_valid = 0;
  endtask

  // Counts cycles until mem_ready, watching ld_ready and a_q0 along the way
  task automatic wait_ready(output int n, output logic saw_ldr, output logic saw_q);
    n = 0; saw_ldr = 0; saw_q = 0;
    while (!mem_ready && n < 200) begin
      saw_ldr |= ld_ready;
      saw_q   |= (a_q0 != 0);
      tick;
      n++;
    end
  endtask

  initial begin
    logic [31:0] q;
    int          n;
    logic        sl, sq, bad;

    ap_rst = 1; a_address0 = 0; b_address0 = 0; ld_addr = 0;
    a_ad0 = 0; b_ad0 = 0; ld_data = 0; ld_sel = 0;
    idle;
    repeat (3) tick;
    check("rst_a_q0", a_q0, 0);
    check("rst_b_q0", b_q0, 0);
    check("rst_mem_ready", {31'd0, mem_ready}, 0);
    check("rst_errs", {30'd0, a_err, b_err}, 0);
    check("rst_ld_ready", {31'd0, ld_ready}, 0);

    // Clear sweep length
    ap_rst = 0;
    wait_ready(n, sl, sq);
    check("clear_len", n, 64);
    check("clear_ld_ready", {31'd0, sl}, 0);
    rd_a(5, q);
    check("clr_A5", q, 0);

    // Preload and pipelined back-to-back reads on both arrays
    for (int i = 0; i < 4; i++) preload(0, i, i + 1);
    for (int i = 0; i < 4; i++) preload(1, i, i + 5);
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        check("pipe_a", a_q0, k - 1);
        check("pipe_b", b_q0, k + 3);
      end
      if (k < 4) begin
        a_ce0 = 1; a_we0 = 0; a_address0 = k;
        b_ce0 = 1; b_we0 = 0; b_address0 = k;
      end else begin
        a_ce0 = 0; b_ce0 = 0;
      end
      tick;
    end
    tick; tick;
    check("hold_a", a_q0, 4);
    check("hold_b", b_q0, 8);

    // Kernel write blocks a preload to the same array
    a_ce0 = 1; a_we0 = 1; a_address0 = 7; a_ad0 = 32'hDEAD;
    ld_valid = 1; ld_sel = 0; ld_addr = 9; ld_data = 32'h1234;
    #1 check("ld_blocked", {31'd0, ld_ready}, 0);
    tick;
    a_ce0 = 0; a_we0 = 0;
    #1 check("ld_retry", {31'd0, ld_ready}, 1);
    tick; ld_valid = 0;
    rd_a(7, q); check("A7", q, 32'hDEAD);
    rd_a(9, q); check("A9", q, 32'h1234);

    // Kernel write on B does not block a preload to A
    b_ce0 = 1; b_we0 = 1; b_address0 = 10; b_ad0 = 32'hB0B;
    ld_valid = 1; ld_sel = 0; ld_addr = 11; ld_data = 32'hA11;
    #1 check("ld_other_arr", {31'd0, ld_ready}, 1);
    tick; idle;
    rd_b(10, q); check("B10", q, 32'hB0B);
    rd_a(11, q); check("A11", q, 32'hA11);

    // Write then read the same address on the next cycle
    a_ce0 = 1; a_we0 = 1; a_address0 = 3; a_ad0 = 32'h55;
    tick;
    a_we0 = 0;
    tick;
    a_ce0 = 0;
    check("wr_rd_hold", a_q0, 32'hA11);
    tick;
    check("wr_rd_new", a_q0, 32'h55);

    // Read during a preload of the same address returns old data
    a_ce0 = 1; a_we0 = 0; a_address0 = 2;
    ld_valid = 1; ld_sel = 0; ld_addr = 2; ld_data = 32'h77;
    #1 check("pl_same_rdy", {31'd0, ld_ready}, 1);
    tick; idle;
    tick;
    check("rd_old", a_q0, 3);
    rd_a(2, q); check("rd_after_pl", q, 32'h77);

    // Out-of-range accesses
    preload(0, 5, 32'h99);
    rd_b(64, q);
    check("oor_b_q", q, 0);
    check("oor_b_err", {31'd0, b_err}, 1);
    check("oor_a_clean", {31'd0, a_err}, 0);
    b_ce0 = 1; b_we0 = 1; b_address0 = 70; b_ad0 = 32'hFFFF;
    tick; idle;
    rd_b(6, q); check("oor_wr_drop", q, 0);
    rd_a(32'h8000_0005, q);
    check("oor_hi_bits", q, 0);
    check("oor_a_err", {31'd0, a_err}, 1);
    repeat (5) tick;
    check("err_sticky", {30'd0, a_err, b_err}, 2'b11);

    // Reset with reads in flight, then a reset mid-sweep
    rd_a(3, q); check("pre_rst", q, 32'h55);
    a_ce0 = 1; a_we0 = 0; a_address0 = 1;
    tick;
    a_address0 = 2; ap_rst = 1;
    tick; idle;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      bad |= (a_q0 != 0);
      tick;
    end
    check("flush_q0", {31'd0, bad}, 0);
    check("flush_errs", {30'd0, a_err, b_err}, 0);
    check("flush_mem_ready", {31'd0, mem_ready}, 0);
    ap_rst = 0;
    repeat (10) begin
      bad |= (a_q0 != 0) | mem_ready;
      tick;
    end
    ap_rst = 1;
    tick;
    ap_rst = 0;
    check("midclr_quiet", {31'd0, bad}, 0);
    wait_ready(n, sl, sq);
    check("reclear_len", n, 64);
    check("reclear_ld_ready", {31'd0, sl}, 0);
    check("reclear_q0", {31'd0, sq}, 0);
    rd_a(1, q); check("reclear_A1", q, 0);
    rd_b(2, q); check("reclear_B2", q, 0);

    // Out-of-range preload sets only the target's flag
    preload(1, 100, 32'h1);
    check("oor_pl_b", {31'd0, b_err}, 1);
    check("oor_pl_a", {31'd0, a_err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
